// File: rtl/lsu_sram_responder.sv
// lsu_sram_responder: AXI4-Lite-style slave on the LSU data bus, backed by a
// word-organised SRAM array. Independent read and write FSMs, each with a
// programmable response latency. Single outstanding transaction per channel.
module lsu_sram_responder #(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] LP_SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  LP_RLOAD    = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  LP_WLOAD    = 4'(WRITE_LATENCY - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_t;

  // Byte address falls inside the array window (unsigned offset compare).
  function automatic logic f_in_range(input logic [31:0] addr);
    return ((addr - BASE_ADDR) < LP_SPAN);
  endfunction

  // Word index of a byte address; the low two address bits are ignored.
  function automatic logic [AW-1:0] f_index(input logic [31:0] addr);
    return AW'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [31:0]   r_mem [DEPTH];

  rstate_t       r_rstate;
  logic [3:0]    r_rcnt;
  logic [AW-1:0] r_ridx;
  logic          r_rok;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic [1:0]    r_rresp;

  wstate_t       r_wstate;
  logic [3:0]    r_wcnt;
  logic          r_aw_got;
  logic          r_w_got;
  logic [AW-1:0] r_widx;
  logic          r_wok;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_bvalid;
  logic [1:0]    r_bresp;

  logic          w_commit;

  assign w_commit = (r_wstate == W_WAIT) && (r_wcnt == 4'd0) && r_wok;

  assign io_slave_arready = (r_rstate == R_IDLE);
  assign io_slave_awready = (r_wstate == W_IDLE) && !r_aw_got;
  assign io_slave_wready  = (r_wstate == W_IDLE) && !r_w_got;
  assign io_slave_rvalid  = r_rvalid;
  assign io_slave_rdata   = r_rdata;
  assign io_slave_rresp   = r_rresp;
  assign io_slave_bvalid  = r_bvalid;
  assign io_slave_bresp   = r_bresp;

  // Read FSM: accept AR, count down the latency, sample the array, hold R until taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= 4'd0;
      r_ridx   <= '0;
      r_rok    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (io_slave_arvalid) begin
            r_ridx   <= f_index(io_slave_araddr);
            r_rok    <= f_in_range(io_slave_araddr);
            r_rcnt   <= LP_RLOAD;
            r_rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rcnt == 4'd0) begin
            r_rdata  <= r_rok ? r_mem[r_ridx] : 32'd0;
            r_rresp  <= r_rok ? RESP_OKAY : RESP_SLVERR;
            r_rstate <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - 4'd1;
          end
        end
        R_RESP: begin
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
          end else if (io_slave_rready) begin
            r_rvalid <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  // Write FSM: capture AW and W in any order, count down the latency, then hold B until taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= 4'd0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_widx   <= '0;
      r_wok    <= 1'b0;
      r_wdata  <= 32'd0;
      r_wstrb  <= 4'd0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (io_slave_awvalid && !r_aw_got) begin
            r_aw_got <= 1'b1;
            r_widx   <= f_index(io_slave_awaddr);
            r_wok    <= f_in_range(io_slave_awaddr);
          end
          if (io_slave_wvalid && !r_w_got) begin
            r_w_got <= 1'b1;
            r_wdata <= io_slave_wdata;
            r_wstrb <= io_slave_wstrb;
          end
          if ((r_aw_got || io_slave_awvalid) && (r_w_got || io_slave_wvalid)) begin
            r_wcnt   <= LP_WLOAD;
            r_wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_bresp  <= r_wok ? RESP_OKAY : RESP_SLVERR;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        W_RESP: begin
          if (!r_bvalid) begin
            r_bvalid <= 1'b1;
          end else if (io_slave_bready) begin
            r_bvalid <= 1'b0;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
          r_bvalid <= 1'b0;
          r_aw_got <= 1'b0;
          r_w_got  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: byte-lane commit on the last latency cycle; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[r_widx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/lsu_sram_responder.md
Name: lsu_sram_responder

Overview:
- AXI4-Lite-style slave memory on the load/store unit's data bus: the responder end of the LSU master's AW/W/B/AR/R channels.
- Backs a word-organised SRAM array with independent read and write FSMs and programmable response latency.
- Used as the data-memory model and bus endpoint in standalone core simulation.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LATENCY, 2, cycles from AR handshake to rvalid rising (range 1..15).
- WRITE_LATENCY, 2, cycles from capture of both AW and W to bvalid rising (range 1..15).

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_slave_awvalid  input  1 / io_slave_awready  output  1 / io_slave_awaddr  input  32
- io_slave_wvalid  input  1 / io_slave_wready  output  1 / io_slave_wdata  input  32 / io_slave_wstrb  input  4
- io_slave_bvalid  output  1 / io_slave_bready  input  1 / io_slave_bresp  output  2
- io_slave_arvalid  input  1 / io_slave_arready  output  1 / io_slave_araddr  input  32
- io_slave_rvalid  output  1 / io_slave_rready  input  1 / io_slave_rresp  output  2 / io_slave_rdata  output  32

Behaviour:
- Reset (reset low, async): both FSMs go to IDLE, latency counters cleared, capture flags cleared. Outputs: arready=1, awready=1, wready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0. Array contents are not reset.
- Address decode: off = addr - BASE_ADDR, index = off[31:2]. addr[1:0] is ignored; the master pre-rotates data and strobes. In range iff off < DEPTH*4 (unsigned), else out of range.
- Responses: OKAY=2'b00. Out of range gives SLVERR=2'b10.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - arready = (state==R_IDLE), decoded from state.
  - R_IDLE: on arvalid&&arready, latch the address, load counter with READ_LATENCY-1, go to R_WAIT.
  - R_WAIT: decrement. At 0, register rdata = array[index] (0 if out of range) and rresp, then go to R_RESP.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready. On rvalid&&rready, go to R_IDLE and drop rvalid next cycle.
  - Net timing: rvalid rises exactly READ_LATENCY+1 edges after the AR handshake edge.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: awready = !aw_got, wready = !w_got.
  - AW and W may handshake in the same cycle or in either order. Each is latched once and its flag set.
  - When both flags are set (including same-cycle), load counter with WRITE_LATENCY-1 and go to W_WAIT. awready and wready are 0 outside W_IDLE.
  - W_WAIT: at count 0, commit the write and go to W_RESP. Commit rule: for each i with wstrb[i]=1, array[index][8i+7:8i] = wdata[8i+7:8i]. No commit if out of range (bresp=SLVERR).
  - W_RESP: bvalid=1 until bready. On handshake, clear flags and return to W_IDLE.
- Channel independence: read and write FSMs run concurrently.
  - Read sample and write commit on the same edge to the same word: read returns the pre-write data.
  - A read started after bvalid rises returns the new data.
- wstrb=4'b0000: legal; no bytes change, bresp=OKAY.
- Back-pressure:
  - bready/rready held low: responses stay valid and stable; no new AR/AW/W accepted.
  - valid dropped before handshake: nothing captured.
- Reset mid-transaction: the transaction is aborted. No partial write occurs unless the commit edge has already passed. No response is issued after reset release.
- Single outstanding transaction per direction; no IDs, no bursts.

Test Plan:
1. Reset, then AW+W same cycle: addr 0x8000_0010, data 0xDEADBEEF, strb 4'hF, bready=1 -> bvalid exactly 3 edges after handshake, bresp=00. Then AR 0x8000_0010 -> rvalid 3 edges after AR handshake, rdata=0xDEADBEEF, rresp=00.
2. Byte strobes on the word from scenario 1: strb 4'b0010, wdata 0x0000_5500, with AW two cycles before W -> no progress until W arrives. Readback = 0xDEAD55EF.
3. Out of range: AR 0x8000_1000 with DEPTH=1024 -> rresp=10, rdata=0. Write to 0x7FFF_FFFC -> bresp=10, array unchanged.
4. Back-pressure: rready=0 for 5 cycles after rvalid -> rvalid and rdata stable and arready=0 throughout. Handshake on rready=1, arready=1 next cycle.
5. Concurrent read and write to the same word, timed so read sample and write commit share an edge -> read returns old value. A follow-up read returns the new value.
6. Assert reset while the read FSM is in R_WAIT and the write FSM is in W_WAIT -> rvalid/bvalid stay 0, readies return to 1, write not committed.
